// File: rtl/seg_scan.sv
// Multiplexed driver for a bank of active-low seven-segment digits with decimal points.
// Updates are buffered and swapped in only at frame end so the display never tears.
module seg_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic                  in_blz,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [8*DIGITS-1:0]   seg_all,
  output logic                  frame_tick
);

  localparam int PW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0]     r_pend_data;
  logic [DIGITS-1:0]       r_pend_dp;
  logic                    r_pend_blz;
  logic                    r_pend_full;
  logic [4*DIGITS-1:0]     r_act_data;
  logic [DIGITS-1:0]       r_act_dp;
  logic                    r_act_blz;
  logic                    r_loaded;
  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [7:0]              r_seg_out;
  logic [DIGITS-1:0]       r_dig_sel;
  logic [8*DIGITS-1:0]     r_seg_all;
  logic                    r_frame_tick;

  logic                    w_wrap;
  logic                    w_frame_end;
  logic                    w_accept;
  logic [IW-1:0]           w_top;
  logic [DIGITS-1:0][7:0]  w_img;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    case (n)
      4'h0: f_hex = 8'hC0;
      4'h1: f_hex = 8'hF9;
      4'h2: f_hex = 8'hA4;
      4'h3: f_hex = 8'hB0;
      4'h4: f_hex = 8'h99;
      4'h5: f_hex = 8'h92;
      4'h6: f_hex = 8'h82;
      4'h7: f_hex = 8'hF8;
      4'h8: f_hex = 8'h80;
      4'h9: f_hex = 8'h90;
      4'hA: f_hex = 8'h88;
      4'hB: f_hex = 8'h83;
      4'hC: f_hex = 8'hC6;
      4'hD: f_hex = 8'hA1;
      4'hE: f_hex = 8'h86;
      default: f_hex = 8'h8E;
    endcase
  endfunction

  assign w_wrap      = (r_presc == PW'(DIV - 1));
  assign w_frame_end = w_wrap && (r_idx == IW'(DIGITS - 1));
  assign w_accept    = in_valid && !r_pend_full;

  // Image of every digit from the active buffer; w_top is the highest nonzero digit.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_act_data[4*i +: 4] != 4'h0) w_top = IW'(i);
    end
    for (int i = 0; i < DIGITS; i++) begin
      w_img[i] = 8'hFF;
      if (r_loaded) begin
        if (r_act_blz && (i > int'(w_top)))
          w_img[i] = r_act_dp[i] ? 8'h7F : 8'hFF;
        else
          w_img[i] = f_hex(r_act_data[4*i +: 4]) & {~r_act_dp[i], 7'h7F};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blz   <= 1'b0;
      r_pend_full  <= 1'b0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_blz    <= 1'b0;
      r_loaded     <= 1'b0;
      r_presc      <= '0;
      r_idx        <= '0;
      r_seg_out    <= 8'hFF;
      r_dig_sel    <= '1;
      r_seg_all    <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + PW'(1);
      if (w_wrap)
        r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);

      // Accept needs an empty pending slot and transfer needs a full one, so they never collide.
      if (w_frame_end && r_pend_full) begin
        r_act_data  <= r_pend_data;
        r_act_dp    <= r_pend_dp;
        r_act_blz   <= r_pend_blz;
        r_loaded    <= 1'b1;
        r_pend_full <= 1'b0;
      end
      if (w_accept) begin
        r_pend_data <= in_data;
        r_pend_dp   <= in_dp;
        r_pend_blz  <= in_blz;
        r_pend_full <= 1'b1;
      end

      r_frame_tick <= w_frame_end;
      r_dig_sel    <= (r_presc == '0) ? '1 : ~(DIGITS'(1) << r_idx);
      r_seg_out    <= w_img[r_idx];
      r_seg_all    <= w_img;
    end
  end

  assign in_ready   = !r_pend_full;
  assign seg_out    = r_seg_out;
  assign dig_sel    = r_dig_sel;
  assign seg_all    = r_seg_all;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DIGITS=4, DIV=4 (16-cycle frame).
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_dp;
  logic        in_blz;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic [31:0] seg_all;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  int edges    = 0;

  seg_scan #(.DIGITS(4), .DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dp      (in_dp),
    .in_blz     (in_blz),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .seg_all    (seg_all),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_tick && n < 40);
    chk(tag, {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic apply(input logic [15:0] d, input logic [3:0] dp, input logic blz,
                       input logic [31:0] exp, input string tag);
    in_valid = 1'b1; in_data = d; in_dp = dp; in_blz = blz;
    tick();
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_frame({tag, "_tick"});
    tick();
    chk(tag, seg_all, exp);
  endtask

  initial begin
    logic [3:0]  exp_sel;
    logic [7:0]  exp_byte [4];
    int          s;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dp = '0; in_blz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg_out", {24'd0, seg_out}, 32'hFF);
    chk("rst_dig_sel", {28'd0, dig_sel}, 32'hF);
    chk("rst_seg_all", seg_all, 32'hFFFF_FFFF);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    edges = 0;

    // Three unloaded frames: blank digits, scan pattern with dead slot, tick every 16.
    for (int k = 1; k <= 48; k++) begin
      tick();
      s = k - 1;
      exp_sel = ((s % 4) == 0) ? 4'hF : ~(4'b0001 << ((s / 4) % 4));
      chk("scan_dig_sel", {28'd0, dig_sel}, {28'd0, exp_sel});
      chk("scan_tick", {31'd0, frame_tick}, {31'd0, (k % 16) == 0});
      chk("scan_seg_out", {24'd0, seg_out}, 32'hFF);
      chk("scan_seg_all", seg_all, 32'hFFFF_FFFF);
    end

    in_valid = 1'b1; in_data = 16'h12AF; in_dp = 4'b0100; in_blz = 1'b0;
    tick();
    chk("load_ready_low", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_frame("load_tick");
    chk("load_edge_mod", edges % 16, 32'd0);
    chk("load_no_early", seg_all, 32'hFFFF_FFFF);
    chk("load_ready_high", {31'd0, in_ready}, 32'd1);
    tick();
    chk("load_seg_all", seg_all, 32'hF924_888E);
    chk("load_seg_out0", {24'd0, seg_out}, 32'h8E);
    exp_byte[0] = 8'h8E; exp_byte[1] = 8'h88; exp_byte[2] = 8'h24; exp_byte[3] = 8'hF9;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("load_seg_out", {24'd0, seg_out}, {24'd0, exp_byte[((edges - 1) % 16) / 4]});
    end

    apply(16'h0050, 4'b0000, 1'b1, 32'hFFFF_92C0, "blz_0050");
    apply(16'h0000, 4'b0000, 1'b1, 32'hFFFF_FFC0, "blz_0000");
    apply(16'h0050, 4'b0000, 1'b0, 32'hC0C0_92C0, "noblz_0050");
    apply(16'h0000, 4'b1000, 1'b1, 32'h7FFF_FFC0, "blz_dp3");

    // Back-to-back: B is held on the bus while A waits in pending.
    in_valid = 1'b1; in_data = 16'h3456; in_dp = 4'b0000; in_blz = 1'b0;
    tick();
    chk("b2b_a_accept", {31'd0, in_ready}, 32'd0);
    in_data = 16'h789E; in_dp = 4'b0001;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (frame_tick) break;
      chk("b2b_stall_ready", {31'd0, in_ready}, 32'd0);
      chk("b2b_stall_hold", seg_all, 32'h7FFF_FFC0);
    end
    chk("b2b_tick1", {31'd0, frame_tick}, 32'd1);
    chk("b2b_ready_rise", {31'd0, in_ready}, 32'd1);
    chk("b2b_hold_at_tick", seg_all, 32'h7FFF_FFC0);
    tick();
    chk("b2b_show_a", seg_all, 32'hB099_9282);
    chk("b2b_b_accept", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("b2b_a_stable", seg_all, 32'hB099_9282);
      if (frame_tick) break;
    end
    chk("b2b_tick2", {31'd0, frame_tick}, 32'd1);
    tick();
    chk("b2b_show_b", seg_all, 32'hF880_9006);

    // Offer on the frame-end cycle itself.
    for (int k = 0; k < 16 && (edges % 16) != 15; k++) tick();
    in_valid = 1'b1; in_data = 16'hABCD; in_dp = 4'b0000; in_blz = 1'b0;
    tick();
    chk("fe_tick", {31'd0, frame_tick}, 32'd1);
    chk("fe_accept", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("fe_not_shown", seg_all, 32'hF880_9006);
    end
    chk("fe_tick2", {31'd0, frame_tick}, 32'd1);
    tick();
    chk("fe_shown", seg_all, 32'h8883_C6A1);

    // Async reset mid-slot with an update still pending.
    in_valid = 1'b1; in_data = 16'h1111; in_dp = 4'b1111; in_blz = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("ar_pending", {31'd0, in_ready}, 32'd0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_seg_out", {24'd0, seg_out}, 32'hFF);
    chk("ar_dig_sel", {28'd0, dig_sel}, 32'hF);
    chk("ar_seg_all", seg_all, 32'hFFFF_FFFF);
    chk("ar_tick", {31'd0, frame_tick}, 32'd0);
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    edges = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("ar_lost", seg_all, 32'hFFFF_FFFF);
      chk("ar_tick_period", {31'd0, frame_tick}, {31'd0, (k % 16) == 0});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
